// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the oversampling UART receiver: arms the receiver,
// buffers words in a FWFT FIFO, tracks consecutive errors and idle-gap frame boundaries.
module uart_rx_ctrl #(
   parameter int WORD_SIZE    = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int IDLE_TIMEOUT = 160,
   parameter int MAX_ERRORS   = 3
) (
   input  logic                              Clk_Rx,
   input  logic                              Rst_Rx,
   input  logic                              Enable,
   input  logic                              Clear_Faults,
   output logic                              Rx_Start,
   input  logic [WORD_SIZE-1:0]              Rx_Data,
   input  logic                              Rx_Done,
   input  logic                              Rx_Busy,
   input  logic                              Rx_Error,
   output logic [WORD_SIZE-1:0]              M_Data,
   output logic                              M_Valid,
   input  logic                              M_Ready,
   output logic                              Frame_End,
   output logic [7:0]                        Frame_Len,
   output logic [$clog2(MAX_ERRORS+1)-1:0]   Err_Count,
   output logic                              Overflow,
   output logic                              Fault,
   output logic [2:0]                        Dbg_State
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(IDLE_TIMEOUT+1);
   localparam int EW = $clog2(MAX_ERRORS+1);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_P  = (AW+1)'(FIFO_DEPTH);
   localparam logic [IW-1:0] IDLE_ONE = IW'(1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
   localparam logic [EW-1:0] ERR_ONE  = EW'(1);
   localparam logic [EW-1:0] ERR_MAX  = EW'(MAX_ERRORS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RECV  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t                state, state_next;
   logic                  guard;
   logic [WORD_SIZE-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr, count, count_next;
   logic                  empty, full, pop, push, drop, full_after;
   logic [EW-1:0]         err_next;
   logic [IW-1:0]         idle_cnt;
   logic [7:0]            frame_cnt;
   logic                  close_frame;

   // Valid/ready: a word moves on every cycle where M_Valid and M_Ready are both high;
   // M_Data is the head entry and stays stable until that cycle.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count      = wr_ptr - rd_ptr;
   assign pop        = M_Valid && M_Ready;
   assign push       = Rx_Done && (!full || pop);
   assign drop       = Rx_Done && full && !pop;
   assign M_Valid    = !empty;
   assign M_Data     = mem[rd_ptr[AW-1:0]];
   assign full_after = (count_next == DEPTH_P);

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + PTR_ONE;
      else if (pop && !push) count_next = count - PTR_ONE;
   end

   always_comb begin
      err_next = Err_Count;
      if (Clear_Faults || Rx_Done)          err_next = '0;
      else if (Rx_Error && Err_Count != ERR_MAX) err_next = Err_Count + ERR_ONE;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (Enable) state_next = full ? S_HOLD : S_ARM;
         S_ARM: begin
            if (!Enable)                state_next = S_IDLE;
            else if (Rx_Busy && !guard) state_next = S_RECV;
         end
         S_RECV: begin
            if (Rx_Done)
               state_next = full_after ? S_HOLD : (Enable ? S_ARM : S_IDLE);
            else if (Rx_Error)
               state_next = (err_next == ERR_MAX) ? S_FAULT : (Enable ? S_ARM : S_IDLE);
         end
         S_HOLD:  if (!full) state_next = Enable ? S_ARM : S_IDLE;
         S_FAULT: if (Clear_Faults) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign Rx_Start  = (state == S_ARM);
   assign Fault     = (state == S_FAULT);
   assign Dbg_State = state;

   // The guard spans the first ARM cycle after a word, masking the receiver's Busy tail.
   always_ff @(posedge Clk_Rx) begin
      if (Rst_Rx) begin
         state <= S_IDLE;
         guard <= 1'b0;
      end else begin
         state <= state_next;
         guard <= (state == S_RECV) && (state_next == S_ARM);
      end
   end

   always_ff @(posedge Clk_Rx) begin
      if (push) mem[wr_ptr[AW-1:0]] <= Rx_Data;
   end

   always_ff @(posedge Clk_Rx) begin
      if (Rst_Rx) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         Err_Count <= '0;
         Overflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         Err_Count <= err_next;
         if (Clear_Faults) Overflow <= 1'b0;
         else if (drop)    Overflow <= 1'b1;
      end
   end

   assign close_frame = !Rx_Done && (idle_cnt == IDLE_MAX - IDLE_ONE) && (frame_cnt != 8'd0);

   always_ff @(posedge Clk_Rx) begin
      if (Rst_Rx) begin
         idle_cnt  <= '0;
         frame_cnt <= 8'd0;
         Frame_End <= 1'b0;
         Frame_Len <= 8'd0;
      end else begin
         if (Rx_Done)                   idle_cnt <= '0;
         else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_ONE;
         Frame_End <= close_frame;
         if (close_frame) begin
            Frame_Len <= frame_cnt;
            frame_cnt <= 8'd0;
         end else if (push && frame_cnt != 8'd255) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized bench for uart_rx_ctrl with a queue-based FIFO/error model.
module tb_uart_rx_ctrl;

   localparam int W     = 8;
   localparam int DEPTH = 8;
   localparam int MAXE  = 3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARM   = 3'd1;
   localparam logic [2:0] ST_RECV  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   logic          Clk_Rx, Rst_Rx, Enable, Clear_Faults, Rx_Start;
   logic [W-1:0]  Rx_Data, M_Data;
   logic          Rx_Done, Rx_Busy, Rx_Error, M_Valid, M_Ready;
   logic          Frame_End, Overflow, Fault;
   logic [7:0]    Frame_Len;
   logic [1:0]    Err_Count;
   logic [2:0]    Dbg_State;

   uart_rx_ctrl dut (
      .Clk_Rx(Clk_Rx), .Rst_Rx(Rst_Rx), .Enable(Enable), .Clear_Faults(Clear_Faults),
      .Rx_Start(Rx_Start), .Rx_Data(Rx_Data), .Rx_Done(Rx_Done), .Rx_Busy(Rx_Busy),
      .Rx_Error(Rx_Error), .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
      .Frame_End(Frame_End), .Frame_Len(Frame_Len), .Err_Count(Err_Count),
      .Overflow(Overflow), .Fault(Fault), .Dbg_State(Dbg_State)
   );

   initial Clk_Rx = 1'b0;
   always #5 Clk_Rx = ~Clk_Rx;

   int           n_asserts = 0;
   int           n_fail    = 0;
   logic [W-1:0] exp_q[$];
   bit           exp_ovf   = 1'b0;
   int           exp_err   = 0;
   bit           model_on  = 1'b0;
   bit           rand_ready = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model sees the inputs the DUT will sample at the coming edge.
   task automatic tick();
      bit popped;
      if (rand_ready) M_Ready = 1'($urandom_range(0, 1));
      if (model_on && !Rst_Rx) begin
         chk("m_valid", {31'd0, M_Valid}, {31'd0, exp_q.size() != 0});
         chk("overflow", {31'd0, Overflow}, {31'd0, exp_ovf});
         chk("err_count", {30'd0, Err_Count}, exp_err);
         popped = M_Ready && (exp_q.size() != 0);
         if (popped) begin
            chk("m_data", {24'd0, M_Data}, {24'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
         if (Rx_Done) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(Rx_Data);
            else if (!Clear_Faults)   exp_ovf = 1'b1;
         end
         if (Clear_Faults) exp_ovf = 1'b0;
         if (Clear_Faults || Rx_Done)     exp_err = 0;
         else if (Rx_Error && exp_err < MAXE) exp_err = exp_err + 1;
      end
      @(posedge Clk_Rx);
      #1;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 300 && Rx_Start !== 1'b1; i++) tick();
      chk("rx_start_seen", {31'd0, Rx_Start}, 32'd1);
   endtask

   task automatic enter_recv();
      int n;
      n = 0;
      Rx_Busy = 1'b1;
      do begin
         tick();
         n++;
      end while (Rx_Start === 1'b1 && n < 3);
      chk("state_recv", {29'd0, Dbg_State}, {29'd0, ST_RECV});
   endtask

   task automatic send_word(input logic [W-1:0] d);
      wait_start();
      enter_recv();
      repeat ($urandom_range(0, 3)) tick();
      Rx_Data = d;
      Rx_Done = 1'b1;
      Rx_Busy = 1'b0;
      tick();
      Rx_Done = 1'b0;
      chk("err_after_done", {30'd0, Err_Count}, 32'd0);
   endtask

   task automatic send_error();
      wait_start();
      enter_recv();
      Rx_Error = 1'b1;
      Rx_Busy  = 1'b0;
      tick();
      Rx_Error = 1'b0;
      chk("err_step", {30'd0, Err_Count}, exp_err);
   endtask

   task automatic drain(input int cycles);
      M_Ready = 1'b1;
      repeat (cycles) tick();
      chk("drained", {31'd0, M_Valid}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rx_start"},  {31'd0, Rx_Start},  32'd0);
      chk({tag, "_m_valid"},   {31'd0, M_Valid},   32'd0);
      chk({tag, "_frame_end"}, {31'd0, Frame_End}, 32'd0);
      chk({tag, "_frame_len"}, {24'd0, Frame_Len}, 32'd0);
      chk({tag, "_err_count"}, {30'd0, Err_Count}, 32'd0);
      chk({tag, "_overflow"},  {31'd0, Overflow},  32'd0);
      chk({tag, "_fault"},     {31'd0, Fault},     32'd0);
      chk({tag, "_state"},     {29'd0, Dbg_State}, {29'd0, ST_IDLE});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] d1, d2;
      Rst_Rx = 1'b1; Enable = 1'b0; Clear_Faults = 1'b0; Rx_Data = '0;
      Rx_Done = 1'b0; Rx_Busy = 1'b0; Rx_Error = 1'b0; M_Ready = 1'b0;
      repeat (3) tick();
      check_reset_values("reset");
      Rst_Rx = 1'b0;
      model_on = 1'b1;

      // Basic reception: two words with a ready consumer
      Enable = 1'b1; M_Ready = 1'b1;
      tick();
      chk("arm_start", {31'd0, Rx_Start}, 32'd1);
      chk("arm_state", {29'd0, Dbg_State}, {29'd0, ST_ARM});
      send_word(8'hA5);
      chk("valid_latency_a5", {31'd0, M_Valid}, 32'd1);
      chk("head_a5", {24'd0, M_Data}, 32'hA5);
      send_word(8'h3C);
      chk("valid_latency_3c", {31'd0, M_Valid}, 32'd1);
      chk("head_3c", {24'd0, M_Data}, 32'h3C);
      drain(4);

      // Back-to-back frames: Busy held high across Done
      for (int r = 0; r < 3; r++) begin
         d1 = 8'($urandom); d2 = 8'($urandom);
         wait_start();
         enter_recv();
         Rx_Data = d1; Rx_Done = 1'b1;
         tick();
         Rx_Done = 1'b0;
         chk("b2b_arm", {29'd0, Dbg_State}, {29'd0, ST_ARM});
         tick();
         chk("b2b_guard", {29'd0, Dbg_State}, {29'd0, ST_ARM});
         tick();
         chk("b2b_recv", {29'd0, Dbg_State}, {29'd0, ST_RECV});
         Rx_Data = d2; Rx_Done = 1'b1; Rx_Busy = 1'b0;
         tick();
         Rx_Done = 1'b0;
      end
      drain(4);

      // Fill to full, overflow drop, full-with-pop, then release from HOLD
      M_Ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_word(8'($urandom));
      chk("hold_state", {29'd0, Dbg_State}, {29'd0, ST_HOLD});
      chk("hold_start", {31'd0, Rx_Start}, 32'd0);
      chk("hold_no_ovf", {31'd0, Overflow}, 32'd0);
      repeat (3) tick();
      chk("hold_stays", {29'd0, Dbg_State}, {29'd0, ST_HOLD});
      Rx_Data = 8'($urandom); Rx_Done = 1'b1;
      tick();
      Rx_Done = 1'b0;
      chk("ovf_set", {31'd0, Overflow}, 32'd1);
      Rx_Data = 8'($urandom); Rx_Done = 1'b1; M_Ready = 1'b1;
      tick();
      Rx_Done = 1'b0; M_Ready = 1'b0;
      chk("full_pop_push", {31'd0, Overflow}, 32'd1);
      chk("full_pop_hold", {29'd0, Dbg_State}, {29'd0, ST_HOLD});
      Clear_Faults = 1'b1;
      tick();
      Clear_Faults = 1'b0;
      chk("ovf_cleared", {31'd0, Overflow}, 32'd0);
      M_Ready = 1'b1;
      tick();
      M_Ready = 1'b0;
      tick();
      chk("hold_to_arm", {29'd0, Dbg_State}, {29'd0, ST_ARM});
      send_word(8'($urandom));
      drain(12);

      // Error counting, FAULT, and clearing (one word parked in the FIFO)
      M_Ready = 1'b0;
      send_error();
      chk("err1_state", {29'd0, Dbg_State}, {29'd0, ST_ARM});
      send_word(8'($urandom));
      for (int e = 1; e <= MAXE; e++) begin
         send_error();
         chk("err_value", {30'd0, Err_Count}, e);
      end
      chk("fault_flag", {31'd0, Fault}, 32'd1);
      chk("fault_start", {31'd0, Rx_Start}, 32'd0);
      chk("fault_state", {29'd0, Dbg_State}, {29'd0, ST_FAULT});
      Rx_Error = 1'b1;
      tick();
      Rx_Error = 1'b0;
      chk("err_saturate", {30'd0, Err_Count}, 32'd3);
      M_Ready = 1'b1;
      repeat (3) tick();
      chk("fault_drained", {31'd0, M_Valid}, 32'd0);
      chk("fault_holds", {29'd0, Dbg_State}, {29'd0, ST_FAULT});
      Clear_Faults = 1'b1; Rx_Error = 1'b1;
      tick();
      Clear_Faults = 1'b0; Rx_Error = 1'b0;
      chk("clear_err", {30'd0, Err_Count}, 32'd0);
      chk("clear_fault", {31'd0, Fault}, 32'd0);
      chk("clear_idle", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
      tick();
      chk("clear_arm", {29'd0, Dbg_State}, {29'd0, ST_ARM});

      // Idle-gap framing: close any open frame, then 5 words and a long gap
      Enable = 1'b0;
      drain(170);
      Enable = 1'b1;
      for (int i = 0; i < 5; i++) send_word(8'($urandom));
      for (int k = 1; k <= 170; k++) begin
         tick();
         chk("frame_end", {31'd0, Frame_End}, {31'd0, k == 160});
         if (k == 160) chk("frame_len", {24'd0, Frame_Len}, 32'd5);
      end
      chk("frame_len_hold", {24'd0, Frame_Len}, 32'd5);

      // Randomized traffic with a random consumer
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) send_word(8'($urandom));
      rand_ready = 1'b0;
      drain(20);

      // Reset mid-frame with words buffered
      M_Ready = 1'b0;
      for (int i = 0; i < 3; i++) send_word(8'($urandom));
      wait_start();
      enter_recv();
      Rst_Rx = 1'b1;
      model_on = 1'b0;
      tick();
      check_reset_values("midreset");
      Rst_Rx = 1'b0; Rx_Busy = 1'b0; Enable = 1'b0;
      exp_q.delete(); exp_ovf = 1'b0; exp_err = 0;
      model_on = 1'b1;
      repeat (3) tick();
      chk("post_reset_empty", {31'd0, M_Valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
